// File: rtl/clk_speed_ctrl.sv
// clk_speed_ctrl: speed-select controller for the DigitalClock 1 Hz divider.
// Two raw push-buttons step through five speed levels (x1..x10000). The controller
// drives the divider's one-hot quick code and reverts to x1 after TIMEOUT_TICKS
// divided-clock ticks with no button activity.
//
// Ports:
//   clk         system clock
//   rst         asynchronous active-high reset
//   btn_up      raw faster button, active-high, asynchronous
//   btn_down    raw slower button, active-high, asynchronous
//   tick_in     divider output square wave, asynchronous level
//   quick       registered one-hot speed code (0000=x1, 1000=x10 ... 0001=x10000)
//   level       current level index 0..4
//   changed     one-cycle pulse on every level change
//   timeout_hit one-cycle pulse when the auto-revert fires
//
// Build option: define CLK_SPEED_WRAP_EN to make up at L4 wrap to L0 and down at
// L0 wrap to L4; otherwise the level saturates at both ends.
module clk_speed_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned TIMEOUT_TICKS   = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       tick_in,
  output logic [3:0] quick,
  output logic [2:0] level,
  output logic       changed,
  output logic       timeout_hit
);

  localparam int unsigned CntW = 20;
  localparam logic [CntW-1:0] DbLast = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] ToLast = 8'(TIMEOUT_TICKS - 1);
  localparam bit TimeoutEn = (TIMEOUT_TICKS != 0);

  typedef enum logic [2:0] {StL0, StL1, StL2, StL3, StL4} level_e;

  // Index 0 = up, index 1 = down.
  logic [1:0]      btn_meta_q, btn_sync_q;
  logic [1:0]      db_q, db_d, db_prev_q, press_q;
  logic [CntW-1:0] db_cnt_q [2];
  logic [CntW-1:0] db_cnt_d [2];
  // tick_q[0..1] synchroniser, tick_q[2] previous synced value for edge detect.
  logic [2:0]      tick_q;
  logic            tick_rise;

  level_e     state_q, state_d;
  logic [7:0] to_cnt_q, to_cnt_d;
  logic [3:0] quick_q, quick_d;
  logic       changed_q, timeout_q, timeout_d;

  function automatic level_e step_up(level_e s);
    level_e r;
    unique case (s)
      StL0:    r = StL1;
      StL1:    r = StL2;
      StL2:    r = StL3;
      StL3:    r = StL4;
`ifdef CLK_SPEED_WRAP_EN
      StL4:    r = StL0;
`else
      StL4:    r = StL4;
`endif
      default: r = StL0;
    endcase
    return r;
  endfunction

  function automatic level_e step_dn(level_e s);
    level_e r;
    unique case (s)
`ifdef CLK_SPEED_WRAP_EN
      StL0:    r = StL4;
`else
      StL0:    r = StL0;
`endif
      StL1:    r = StL0;
      StL2:    r = StL1;
      StL3:    r = StL2;
      StL4:    r = StL3;
      default: r = StL0;
    endcase
    return r;
  endfunction

  // Debounce: a new level is taken only after DEBOUNCE_CYCLES consecutive mismatches.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      db_d[i]     = db_q[i];
      db_cnt_d[i] = '0;
      if (btn_sync_q[i] != db_q[i]) begin
        if (db_cnt_q[i] == DbLast) begin
          db_d[i] = btn_sync_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  assign tick_rise = tick_q[1] & ~tick_q[2];

  always_comb begin
    state_d   = state_q;
    to_cnt_d  = to_cnt_q;
    timeout_d = 1'b0;
    if (press_q[0] || press_q[1]) begin
      // Any accepted press restarts the idle count, even when ignored or saturated,
      // and wins over a timeout-reaching tick in the same cycle.
      to_cnt_d = '0;
      if (press_q[0] && !press_q[1]) begin
        state_d = step_up(state_q);
      end else if (press_q[1] && !press_q[0]) begin
        state_d = step_dn(state_q);
      end
    end else if (state_q == StL0) begin
      to_cnt_d = '0;
    end else if (tick_rise && TimeoutEn) begin
      if (to_cnt_q == ToLast) begin
        state_d   = StL0;
        timeout_d = 1'b1;
        to_cnt_d  = '0;
      end else begin
        to_cnt_d = to_cnt_q + 8'(1);
      end
    end
  end

  // quick is registered from the next level so it updates with level, glitch-free.
  always_comb begin
    quick_d = 4'b0000;
    unique case (state_d)
      StL1:    quick_d = 4'b1000;
      StL2:    quick_d = 4'b0100;
      StL3:    quick_d = 4'b0010;
      StL4:    quick_d = 4'b0001;
      default: quick_d = 4'b0000;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_meta_q <= '0;
      btn_sync_q <= '0;
      tick_q     <= '0;
      db_q       <= '0;
      db_prev_q  <= '0;
      press_q    <= '0;
      for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
      state_q    <= StL0;
      to_cnt_q   <= '0;
      quick_q    <= '0;
      changed_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      btn_meta_q <= {btn_down, btn_up};
      btn_sync_q <= btn_meta_q;
      tick_q     <= {tick_q[1:0], tick_in};
      db_q       <= db_d;
      db_prev_q  <= db_q;
      press_q    <= db_q & ~db_prev_q;
      for (int i = 0; i < 2; i++) db_cnt_q[i] <= db_cnt_d[i];
      state_q    <= state_d;
      to_cnt_q   <= to_cnt_d;
      quick_q    <= quick_d;
      changed_q  <= (state_d != state_q);
      timeout_q  <= timeout_d;
    end
  end

  assign quick       = quick_q;
  assign level       = state_q;
  assign changed     = changed_q;
  assign timeout_hit = timeout_q;

endmodule

// File: tb/tb_clk_speed_ctrl.sv
// Self-checking bench for clk_speed_ctrl with DEBOUNCE_CYCLES=4, TIMEOUT_TICKS=3.
// A behavioural model tracks the expected level from input histories: a button is
// accepted once its raw value, seen two cycles late, has differed from the accepted
// state for Deb consecutive samples; presses then act two cycles later.
module tb_clk_speed_ctrl;
  localparam int unsigned Deb = 4;
  localparam int unsigned To  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       tick_in = 1'b0;
  logic [3:0] quick;
  logic [2:0] level;
  logic       changed;
  logic       timeout_hit;

  int checks = 0;
  int errors = 0;

  clk_speed_ctrl #(
    .DEBOUNCE_CYCLES(Deb),
    .TIMEOUT_TICKS  (To)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .tick_in    (tick_in),
    .quick      (quick),
    .level      (level),
    .changed    (changed),
    .timeout_hit(timeout_hit)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int         m_level = 0;
  int         m_cnt = 0;
  bit         m_changed = 0, m_to = 0;
  bit         m_db_up = 0, m_db_dn = 0;
  bit         r1_up = 0, r1_dn = 0, pq_up = 0, pq_dn = 0;
  logic [7:0] up_h = '0, dn_h = '0, tk_h = '0;

  function automatic logic [3:0] exp_quick(int l);
    logic [3:0] q;
    q = (l == 0) ? 4'b0000 : 4'(8 >> (l - 1));
    return q;
  endfunction

  task automatic model_step();
    bit mis_up, mis_dn, rise;
    int nl;
    if (rst) begin
      m_level = 0; m_cnt = 0; m_changed = 0; m_to = 0;
      m_db_up = 0; m_db_dn = 0; r1_up = 0; r1_dn = 0; pq_up = 0; pq_dn = 0;
      up_h = '0; dn_h = '0; tk_h = '0;
    end else begin
      rise = tk_h[1] && !tk_h[2];
      nl   = m_level;
      m_to = 0;
      if (pq_up || pq_dn) begin
        m_cnt = 0;
`ifdef CLK_SPEED_WRAP_EN
        if (pq_up && !pq_dn) nl = (m_level + 1) % 5;
        else if (pq_dn && !pq_up) nl = (m_level + 4) % 5;
`else
        if (pq_up && !pq_dn) nl = (m_level == 4) ? 4 : m_level + 1;
        else if (pq_dn && !pq_up) nl = (m_level == 0) ? 0 : m_level - 1;
`endif
      end else if (m_level == 0) begin
        m_cnt = 0;
      end else if (rise && To != 0) begin
        m_cnt++;
        if (m_cnt == int'(To)) begin
          nl = 0; m_to = 1; m_cnt = 0;
        end
      end
      m_changed = (nl != m_level);
      m_level   = nl;
      pq_up = r1_up; pq_dn = r1_dn;
      mis_up = 1; mis_dn = 1;
      for (int i = 1; i <= int'(Deb); i++) begin
        if (up_h[i] == m_db_up) mis_up = 0;
        if (dn_h[i] == m_db_dn) mis_dn = 0;
      end
      r1_up = mis_up && !m_db_up;
      r1_dn = mis_dn && !m_db_dn;
      if (mis_up) m_db_up = !m_db_up;
      if (mis_dn) m_db_dn = !m_db_dn;
      up_h = {up_h[6:0], btn_up};
      dn_h = {dn_h[6:0], btn_down};
      tk_h = {tk_h[6:0], tick_in};
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      model_step();
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; btn_up = 1'b0; btn_down = 1'b0; tick_in = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int nch = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (level !== 3'd0 || quick !== 4'b0000 || changed !== 1'b0 || timeout_hit !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got lvl=%0d q=%b ch=%b to=%b want 0 0000 0 0",
               level, quick, changed, timeout_hit);
    end
    rst = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (changed) nch++;
      checks++;
      if ({level, quick, changed, timeout_hit} !==
          {3'(m_level), exp_quick(m_level), m_changed, m_to}) begin
        errors++;
        $display("FAIL idle c=%0d got lvl=%0d q=%b ch=%b to=%b want lvl=%0d q=%b ch=%b to=%b",
                 c, level, quick, changed, timeout_hit, m_level, exp_quick(m_level),
                 m_changed, m_to);
      end
    end
    checks++;
    if (nch != 0 || level !== 3'd0) begin
      errors++;
      $display("FAIL idle_summary got changes=%0d lvl=%0d want 0 0", nch, level);
    end
  endtask

  task automatic test_up_hold();
    int nch = 0;
    do_reset();
    repeat (4) @(negedge clk);
    btn_up = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (changed) nch++;
      checks++;
      if ({level, quick, changed, timeout_hit} !==
          {3'(m_level), exp_quick(m_level), m_changed, m_to}) begin
        errors++;
        $display("FAIL up_hold c=%0d got lvl=%0d q=%b ch=%b want lvl=%0d q=%b ch=%b",
                 c, level, quick, changed, m_level, exp_quick(m_level), m_changed);
      end
      if (c == 7) begin
        checks++;
        if (level !== 3'd0) begin
          errors++;
          $display("FAIL up_hold_early got lvl=%0d want 0", level);
        end
      end
      if (c == 8) begin
        checks++;
        if (level !== 3'd1 || quick !== 4'b1000 || changed !== 1'b1) begin
          errors++;
          $display("FAIL up_hold_latency got lvl=%0d q=%b ch=%b want 1 1000 1",
                   level, quick, changed);
        end
      end
      if (c == 20) btn_up = 1'b0;
    end
    checks++;
    if (nch != 1) begin
      errors++;
      $display("FAIL up_hold_count got changes=%0d want 1", nch);
    end
  endtask

  task automatic test_glitch();
    int nch = 0;
    do_reset();
    for (int c = 0; c < 135; c++) begin
      @(negedge clk);
      if (changed) nch++;
      checks++;
      if ({level, quick, changed} !== {3'(m_level), exp_quick(m_level), m_changed}) begin
        errors++;
        $display("FAIL glitch c=%0d got lvl=%0d ch=%b want lvl=%0d ch=%b",
                 c, level, changed, m_level, m_changed);
      end
      btn_up = (c < 130) && ((c % 13) < 3);
    end
    checks++;
    if (nch != 0 || level !== 3'd0) begin
      errors++;
      $display("FAIL glitch_summary got changes=%0d lvl=%0d want 0 0", nch, level);
    end
  endtask

  task automatic test_steps();
    int nch = 0;
    int want_lvl, want_nch;
`ifdef CLK_SPEED_WRAP_EN
    want_lvl = 0; want_nch = 5;
`else
    want_lvl = 4; want_nch = 4;
`endif
    do_reset();
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      if (changed) nch++;
      checks++;
      if ({level, quick, changed} !== {3'(m_level), exp_quick(m_level), m_changed}) begin
        errors++;
        $display("FAIL steps c=%0d got lvl=%0d q=%b ch=%b want lvl=%0d q=%b ch=%b",
                 c, level, quick, changed, m_level, exp_quick(m_level), m_changed);
      end
      btn_up = (c < 100) && ((c % 20) < 10);
    end
    checks++;
    if (nch != want_nch || level !== 3'(want_lvl) || quick !== exp_quick(want_lvl)) begin
      errors++;
      $display("FAIL steps_summary got changes=%0d lvl=%0d q=%b want %0d %0d %b",
               nch, level, quick, want_nch, want_lvl, exp_quick(want_lvl));
    end
  endtask

  task automatic test_timeout();
    int nto = 0;
    int nch = 0;
    do_reset();
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      btn_up = (c < 40) && ((c % 20) < 10);
    end
    checks++;
    if (level !== 3'd2) begin
      errors++;
      $display("FAIL timeout_setup got lvl=%0d want 2", level);
    end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (timeout_hit) nto++;
      if (changed) nch++;
      checks++;
      if ({level, quick, changed, timeout_hit} !==
          {3'(m_level), exp_quick(m_level), m_changed, m_to}) begin
        errors++;
        $display("FAIL timeout c=%0d got lvl=%0d ch=%b to=%b want lvl=%0d ch=%b to=%b",
                 c, level, changed, timeout_hit, m_level, m_changed, m_to);
      end
      tick_in = (c < 24) && ((c % 8) >= 4);
    end
    checks++;
    if (level !== 3'd0 || quick !== 4'b0000 || nto != 1 || nch != 1) begin
      errors++;
      $display("FAIL timeout_summary got lvl=%0d q=%b hits=%0d changes=%0d want 0 0000 1 1",
               level, quick, nto, nch);
    end
    // Press between the second and third tick edges restarts the count.
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      btn_up = (c < 40) && ((c % 20) < 10);
    end
    nto = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (timeout_hit) nto++;
      checks++;
      if ({level, quick, changed, timeout_hit} !==
          {3'(m_level), exp_quick(m_level), m_changed, m_to}) begin
        errors++;
        $display("FAIL timeout_press c=%0d got lvl=%0d ch=%b to=%b want lvl=%0d ch=%b to=%b",
                 c, level, changed, timeout_hit, m_level, m_changed, m_to);
      end
      if (c == 30) begin
        checks++;
        if (level !== 3'd3 || nto != 0) begin
          errors++;
          $display("FAIL timeout_press_hold got lvl=%0d hits=%0d want 3 0", level, nto);
        end
      end
      tick_in = (c % 8) >= 4 && c < 48;
      btn_up  = (c >= 13) && (c < 23);
    end
    checks++;
    if (level !== 3'd0 || nto != 1) begin
      errors++;
      $display("FAIL timeout_press_summary got lvl=%0d hits=%0d want 0 1", level, nto);
    end
  endtask

  task automatic test_both();
    int nch = 0;
    do_reset();
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      btn_up = (c < 40) && ((c % 20) < 10);
    end
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (changed) nch++;
      checks++;
      if ({level, quick, changed} !== {3'(m_level), exp_quick(m_level), m_changed}) begin
        errors++;
        $display("FAIL both c=%0d got lvl=%0d ch=%b want lvl=%0d ch=%b",
                 c, level, changed, m_level, m_changed);
      end
      btn_up   = (c < 12);
      btn_down = (c < 12);
    end
    checks++;
    if (level !== 3'd2 || nch != 0) begin
      errors++;
      $display("FAIL both_summary got lvl=%0d changes=%0d want 2 0", level, nch);
    end
  endtask

  task automatic test_reset_mid();
    int nch = 0;
    do_reset();
    repeat (3) @(negedge clk);
    btn_up = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (changed) nch++;
      checks++;
      if ({level, quick, changed} !== {3'(m_level), exp_quick(m_level), m_changed}) begin
        errors++;
        $display("FAIL reset_mid c=%0d got lvl=%0d ch=%b want lvl=%0d ch=%b",
                 c, level, changed, m_level, m_changed);
      end
      rst = (c >= 3) && (c < 5);
    end
    btn_up = 1'b0;
    checks++;
    if (level !== 3'd1 || nch != 1) begin
      errors++;
      $display("FAIL reset_mid_summary got lvl=%0d changes=%0d want 1 1", level, nch);
    end
  endtask

  task automatic test_random();
    int hu = 0, hd = 0, ht = 0;
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      checks++;
      if ({level, quick, changed, timeout_hit} !==
          {3'(m_level), exp_quick(m_level), m_changed, m_to}) begin
        errors++;
        $display("FAIL random c=%0d got lvl=%0d q=%b ch=%b to=%b want lvl=%0d q=%b ch=%b to=%b",
                 c, level, quick, changed, timeout_hit, m_level, exp_quick(m_level),
                 m_changed, m_to);
      end
      if (hu == 0) begin btn_up = ($urandom_range(0, 2) == 0); hu = $urandom_range(1, 14); end
      if (hd == 0) begin btn_down = ($urandom_range(0, 3) == 0); hd = $urandom_range(1, 14); end
      if (ht == 0) begin tick_in = ~tick_in; ht = $urandom_range(1, 10); end
      hu--; hd--; ht--;
    end
  endtask

  initial begin
    test_reset();
    test_up_hold();
    test_glitch();
    test_steps();
    test_timeout();
    test_both();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
